// File: rtl/mod_addseq_if.sv
// mod_addseq_if: command, operand-fetch, adder and result signals of the
// half-precision add sequencer.
//   slave  : the sequencer itself (mod_addseq)
//   master : whatever drives the sequencer (fetch logic, adder, bench)
interface mod_addseq_if #(
  parameter int CNT_W = 8
);
  // command
  logic             in_Start;
  logic [CNT_W-1:0] in_Count;
  // upstream operand source
  logic             out_Req;
  logic [15:0]      in_Data;
  logic             in_Valid;
  // shared adder
  logic [15:0]      out_AddA;
  logic [15:0]      out_AddB;
  logic             out_AddEn;
  logic [15:0]      in_AddSum;
  logic             in_AddReady;
  // result / status
  logic [15:0]      out_Sum;
  logic             out_Done;
  logic             out_Busy;
  logic             out_Err;

  modport slave (
    input  in_Start, in_Count, in_Data, in_Valid, in_AddSum, in_AddReady,
    output out_Req, out_AddA, out_AddB, out_AddEn, out_Sum, out_Done,
           out_Busy, out_Err
  );

  modport master (
    output in_Start, in_Count, in_Data, in_Valid, in_AddSum, in_AddReady,
    input  out_Req, out_AddA, out_AddB, out_AddEn, out_Sum, out_Done,
           out_Busy, out_Err
  );
endinterface

// File: rtl/mod_addseq.sv
// mod_addseq: issue/collect driver for the shared half-precision adder.
// On a start strobe it pulls in_Count operands from upstream one at a time,
// feeds each to the adder together with the running sum (starting at +0.0),
// and returns the final sum with a one-cycle done pulse. No floating-point
// arithmetic happens here; the adder does all of it.
//
// Optional watchdog: define ADDSEQ_TIMEOUT_EN to abort a run when the adder
// does not answer within TIMEOUT cycles of WAIT. The run then finishes with
// out_Err set and the partial sum on out_Sum. Without the macro WAIT waits
// forever and out_Err is tied low.
module mod_addseq #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  mod_addseq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [15:0]      r_acc;
  logic [15:0]      w_acc_next;
  logic [15:0]      r_add_a;
  logic [15:0]      w_add_a_next;
  logic [15:0]      r_add_b;
  logic [15:0]      w_add_b_next;
  logic [15:0]      r_sum;
  logic [15:0]      w_sum_next;
  logic             w_start_ok;
  logic             w_timeout;

  // a start strobe only counts while idle
  assign w_start_ok = (r_state == S_IDLE) && bus.in_Start;

`ifdef ADDSEQ_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [WD_W-1:0] r_wd;
  logic            r_err;

  // the adder gets TIMEOUT cycles of WAIT; the last one without ready aborts
  assign w_timeout = (r_state == S_WAIT) && !bus.in_AddReady &&
                     (r_wd == WD_W'(TIMEOUT - 1));

  // watchdog: cycles spent in the current WAIT visit, restarted outside WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd <= '0;
    end else if (r_state == S_WAIT) begin
      r_wd <= r_wd + WD_W'(1);
    end else begin
      r_wd <= '0;
    end
  end

  // sticky error flag, cleared only by the next accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_start_ok) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign bus.out_Err = r_err;
`else
  logic w_unused_timeout;

  // no watchdog in this build: WAIT waits for the adder indefinitely
  assign w_timeout        = 1'b0;
  assign w_unused_timeout = |TIMEOUT;
  assign bus.out_Err      = 1'b0;
`endif

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_add_a <= '0;
      r_add_b <= '0;
      r_sum   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_acc   <= w_acc_next;
      r_add_a <= w_add_a_next;
      r_add_b <= w_add_b_next;
      r_sum   <= w_sum_next;
    end
  end

  // next-state and datapath updates; everything holds unless a state moves it
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_acc_next   = r_acc;
    w_add_a_next = r_add_a;
    w_add_b_next = r_add_b;
    w_sum_next   = r_sum;

    case (r_state)
      S_IDLE: begin
        if (bus.in_Start) begin
          w_cnt_next = bus.in_Count;
          w_acc_next = '0;
          if (bus.in_Count == '0) begin
            // empty run: the result is +0.0 straight away
            w_sum_next   = '0;
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        // exactly one operand per visit; leaving FETCH drops out_Req, so a
        // held in_Valid cannot be consumed twice
        if (bus.in_Valid) begin
          w_add_a_next = r_acc;
          w_add_b_next = bus.in_Data;
          w_state_next = S_ISSUE;
        end
      end

      S_ISSUE: begin
        // any ready seen here belongs to an older request and is ignored
        w_state_next = S_WAIT;
      end

      S_WAIT: begin
        if (bus.in_AddReady) begin
          w_acc_next = bus.in_AddSum;
          w_cnt_next = r_cnt - CNT_W'(1);
          if (w_cnt_next == '0) begin
            // publish the sum as DONE is entered so it is valid with out_Done
            w_sum_next   = bus.in_AddSum;
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_FETCH;
          end
        end else if (w_timeout) begin
          // abort: report whatever has been accumulated so far
          w_sum_next   = r_acc;
          w_state_next = S_DONE;
        end
      end

      S_DONE: begin
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // handshake strobes are decoded straight from the state register
  assign bus.out_Req   = (r_state == S_FETCH);
  assign bus.out_AddEn = (r_state == S_ISSUE);
  assign bus.out_Done  = (r_state == S_DONE);
  assign bus.out_Busy  = (r_state != S_IDLE);
  assign bus.out_AddA  = r_add_a;
  assign bus.out_AddB  = r_add_b;
  assign bus.out_Sum   = r_sum;

endmodule

// File: tb/tb_mod_addseq.sv
// tb_mod_addseq: randomized bench for mod_addseq. An upstream operand source
// and an adder model run on the rising edge (+1); the checker samples on the
// falling edge. Expected sums are folds of the operand list through the
// adder's arithmetic (exact half-precision add, or plain 16-bit add).
module tb_mod_addseq;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mod_addseq_if #(.CNT_W(CNT_W)) bus ();

  mod_addseq #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // environment controls
  logic [15:0] src_q[$];
  logic [15:0] run_ops[$];
  int add_lat    = 1;
  int add_serve  = -1;   // issues the adder answers; -1 = all, 0 = hang
  bit float_mode = 1'b0;
  bit stale_mode = 1'b0;
  bit hold_mode  = 1'b0;
  bit gap_mode   = 1'b0;
  int stall_left = 0;

  // half -> real (normals and subnormals)
  function automatic real h2r(input logic [15:0] h);
    real v;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) begin
      v = real'(h[9:0]);
      e = -24;
    end else begin
      v = 1.0 + real'(h[9:0]) / 1024.0;
      e = e - 15;
    end
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return h[15] ? -v : v;
  endfunction

  // real -> half for exactly representable normal values
  function automatic logic [15:0] r2h(input real r);
    real  m;
    int   ex;
    logic s;
    if (r == 0.0) return 16'h0000;
    s  = (r < 0.0);
    m  = s ? -r : r;
    ex = 15;
    while (m >= 2.0) begin m = m / 2.0; ex++; end
    while (m < 1.0)  begin m = m * 2.0; ex--; end
    return {s, 5'(ex), 10'($rtoi((m - 1.0) * 1024.0 + 0.5))};
  endfunction

  function automatic logic [15:0] add16(input logic [15:0] a, input logic [15:0] b, input bit fm);
    if (fm) return r2h(h2r(a) + h2r(b));
    return a + b;
  endfunction

  // upstream operand source: offers the head of src_q while out_Req is high
  bit up_prev_req = 1'b0;
  initial begin
    bus.in_Valid = 1'b0;
    bus.in_Data  = 16'h0000;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        bus.in_Valid = 1'b0;
        up_prev_req  = 1'b0;
      end else begin
        if (up_prev_req && bus.in_Valid && src_q.size() > 0) void'(src_q.pop_front());
        up_prev_req = bus.out_Req;
        bus.in_Valid = 1'b0;
        bus.in_Data  = 16'($urandom);
        if (src_q.size() > 0) begin
          if (hold_mode) begin
            bus.in_Valid = 1'b1;
            bus.in_Data  = src_q[0];
          end else if (bus.out_Req) begin
            if (stall_left > 0) begin
              stall_left--;
            end else if (!(gap_mode && $urandom_range(0, 3) == 0)) begin
              bus.in_Valid = 1'b1;
              bus.in_Data  = src_q[0];
            end
          end
        end
      end
    end
  end

  // adder model: answers add_lat cycles after an enable, optional stale ready
  int          add_cnt = 0;
  logic [15:0] lat_a, lat_b;
  initial begin
    bus.in_AddReady = 1'b0;
    bus.in_AddSum   = 16'h0000;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        add_cnt         = 0;
        bus.in_AddReady = 1'b0;
      end else begin
        bus.in_AddReady = 1'b0;
        if (add_cnt > 0) begin
          add_cnt--;
          if (add_cnt == 0) begin
            bus.in_AddReady = 1'b1;
            bus.in_AddSum   = add16(lat_a, lat_b, float_mode);
          end
        end
        if (bus.out_AddEn) begin
          lat_a   = bus.out_AddA;
          lat_b   = bus.out_AddB;
          add_cnt = (add_serve == 0) ? 0 : add_lat;
          if (add_serve > 0) add_serve--;
          if (stale_mode) begin
            bus.in_AddReady = 1'b1;
            bus.in_AddSum   = 16'hDEAD;
          end
        end
        if (!bus.in_AddReady) bus.in_AddSum = 16'($urandom);
      end
    end
  end

  // one full run over run_ops, checked against the folded reference sum
  task automatic do_run(input string name, input int n, input int lat, input bit fm,
                        input bit stale, input bit hold, input bit gaps, input int stall,
                        input bit poke);
    logic [15:0] ops[$];
    logic [15:0] exp_a[$];
    logic [15:0] acc;
    int cyc, k, req_cyc;
    bit done_seen;
    ops = run_ops;
    acc = 16'h0000;
    foreach (ops[i]) begin
      exp_a.push_back(acc);
      acc = add16(acc, ops[i], fm);
    end
    add_lat = lat; add_serve = -1; float_mode = fm; stale_mode = stale;
    hold_mode = hold; gap_mode = gaps; stall_left = stall; src_q = ops;

    @(negedge clk);
    bus.in_Start = 1'b1;
    bus.in_Count = CNT_W'(n);
    cyc = 0; k = 0; req_cyc = 0; done_seen = 1'b0;
    while (!done_seen && cyc < 200 + n * 40) begin
      @(negedge clk);
      cyc++;
      bus.in_Start = poke && (cyc == 3);
      bus.in_Count = CNT_W'($urandom_range(1, 255));
      if (bus.out_Req) req_cyc++;
      if (bus.out_AddEn) begin
        if (k < n) begin
          check_val("add_a", bus.out_AddA, exp_a[k]);
          check_val("add_b", bus.out_AddB, ops[k]);
        end
        k++;
      end else if (k > 0 && k <= n && bus.in_AddReady) begin
        check_val("hold_a", bus.out_AddA, exp_a[k-1]);
        check_val("hold_b", bus.out_AddB, ops[k-1]);
      end
      if (bus.out_Done) begin
        done_seen = 1'b1;
        check_val("sum", bus.out_Sum, acc);
        check_val("busy_done", bus.out_Busy, 1);
        check_val("err_done", bus.out_Err, 0);
        if (n == 0) check_val("zero_lat", cyc, 1);
      end
    end
    bus.in_Start = 1'b0;
    check_val("done_seen", done_seen, 1);
    check_val("issue_cnt", k, n);
    if (stall > 0) check_val("stall_req", req_cyc, stall + 1);
    if (n == 0) check_val("zero_req", req_cyc, 0);
    @(negedge clk);
    check_val("done_1cyc", bus.out_Done, 0);
    check_val("idle_busy", bus.out_Busy, 0);
    $display("run %s n=%0d lat=%0d sum=%h cycles=%0d", name, n, lat, bus.out_Sum, cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int en, t2, t_done, cyc;
    bit seen;
    bus.in_Start = 1'b0;
    bus.in_Count = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_busy", bus.out_Busy, 0);
    check_val("rst_req", bus.out_Req, 0);
    check_val("rst_en", bus.out_AddEn, 0);
    check_val("rst_done", bus.out_Done, 0);
    check_val("rst_sum", bus.out_Sum, 0);
    check_val("rst_a", bus.out_AddA, 0);
    check_val("rst_b", bus.out_AddB, 0);
    check_val("rst_err", bus.out_Err, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1.0 + 2.0 + 0.5 through an exact two-cycle adder
    run_ops = '{16'h3C00, 16'h4000, 16'h3800};
    do_run("three", 3, 2, 1, 0, 0, 0, 0, 0);
    check_val("sum_3op", bus.out_Sum, 16'h4300);

    // reset while waiting on the adder for the second operand
    src_q = '{16'h1234, 16'h0BCD};
    add_lat = 1; add_serve = 1; float_mode = 0; stale_mode = 0; hold_mode = 0; gap_mode = 0;
    @(negedge clk);
    bus.in_Start = 1'b1;
    bus.in_Count = CNT_W'(2);
    en = 0; cyc = 0;
    while (en < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      bus.in_Start = 1'b0;
      if (bus.out_AddEn) en++;
    end
    check_val("rst_issue2", en, 2);
    repeat (3) @(negedge clk);
    check_val("wait_busy", bus.out_Busy, 1);
    rst = 1'b1;
    #1;
    check_val("mid_busy", bus.out_Busy, 0);
    check_val("mid_req", bus.out_Req, 0);
    check_val("mid_en", bus.out_AddEn, 0);
    check_val("mid_done", bus.out_Done, 0);
    check_val("mid_a", bus.out_AddA, 0);
    check_val("mid_b", bus.out_AddB, 0);
    check_val("mid_sum", bus.out_Sum, 0);
    check_val("mid_err", bus.out_Err, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("mid_nodone", bus.out_Done, 0);
    end
    src_q.delete();
    add_serve = -1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_val("post_rst_done", bus.out_Done, 0);

    // empty run
    run_ops.delete();
    do_run("zero", 0, 1, 0, 0, 0, 0, 0, 0);
    check_val("zero_sum", bus.out_Sum, 0);

    // upstream stalls ten cycles before giving 1.0
    run_ops = '{16'h3C00};
    do_run("stall", 1, 1, 1, 0, 0, 0, 10, 0);
    check_val("stall_sum", bus.out_Sum, 16'h3C00);

    // stale ready during ISSUE plus a start strobe while busy
    run_ops.delete();
    for (int i = 0; i < 4; i++) run_ops.push_back(16'($urandom));
    do_run("stale", 4, 2, 0, 1, 0, 0, 0, 1);

    // in_Valid held high throughout
    run_ops.delete();
    for (int i = 0; i < 5; i++) run_ops.push_back(16'($urandom));
    do_run("hold", 5, 3, 0, 0, 1, 0, 0, 0);

    // random runs
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 12);
      run_ops.delete();
      for (int i = 0; i < n; i++) run_ops.push_back(16'($urandom));
      do_run("rand", n, $urandom_range(1, 4), 0, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1, 0, 1'($urandom_range(0, 1)));
    end

    // largest count
    run_ops.delete();
    for (int i = 0; i < 255; i++) run_ops.push_back(16'($urandom));
    do_run("max", 255, 1, 0, 0, 0, 0, 0, 0);

`ifdef ADDSEQ_TIMEOUT_EN
    // adder answers the first operand, then never again
    src_q = '{16'h0101, 16'h0202, 16'h0303};
    add_lat = 2; add_serve = 1; float_mode = 0; stale_mode = 0; hold_mode = 0; gap_mode = 0;
    @(negedge clk);
    bus.in_Start = 1'b1;
    bus.in_Count = CNT_W'(3);
    en = 0; cyc = 0; t2 = 0; t_done = 0; seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus.in_Start = 1'b0;
      if (bus.out_AddEn) begin
        en++;
        if (en == 2) t2 = cyc;
      end
      if (bus.out_Done) begin
        seen   = 1'b1;
        t_done = cyc;
        check_val("to_err", bus.out_Err, 1);
        check_val("to_sum", bus.out_Sum, add16(16'h0000, 16'h0101, 0));
      end
    end
    check_val("to_done", seen, 1);
    check_val("to_issues", en, 2);
    check_val("to_wait", t_done - t2, TIMEOUT + 1);
    @(negedge clk);
    check_val("to_idle", bus.out_Busy, 0);
    check_val("to_sticky", bus.out_Err, 1);
    src_q.delete();
    add_serve = -1;
    bus.in_Start = 1'b1;
    bus.in_Count = '0;
    @(negedge clk);
    bus.in_Start = 1'b0;
    check_val("to_clr_done", bus.out_Done, 1);
    check_val("to_clr_err", bus.out_Err, 0);
    $display("run timeout issues=%0d wait=%0d", en, t_done - t2);
`else
    check_val("err_tied", bus.out_Err, 0);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
